nrzi_unstuff_decoder: RTL and testbench
=======================================

# nrzi_unstuff_decoder

Parametrised NRZI line decoder with integrated bit-unstuffing and stuff-violation detection for the USB receive path. It sits between the d_plus synchroniser/edge-timing logic and the receive shift register. It samples the synchronised line on each bit strobe and recovers the original bit. Stuffed zeros are removed by withholding `bit_valid`, and more than STUFF_LEN consecutive ones is flagged as an error. IDLE_LEVEL and STUFF_LEN are configurable so the same block serves full-speed (J = 1) and inverted-polarity links, as well as non-USB stuffing rules.

## Interface
- STUFF_LEN, default 6: number of consecutive decoded ones after which the transmitter inserts a zero. Legal range 1..15.
- IDLE_LEVEL, default 1: line level assumed at reset and after `clear`, i.e. the level preceding the first bit.
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- d_plus_sync  input  1  synchronised line level.
- shift_enable  input  1  one-cycle bit strobe: sample the line this cycle.
- clear  input  1  synchronous restart (SOP/EOP); has priority over shift_enable.
- d_orig  output  1  last decoded data bit, held between strobes.
- bit_valid  output  1  one-cycle pulse: d_orig holds a new data bit.
- stuff_err  output  1  one-cycle pulse: stuff violation detected.
- err_flag  output  1  sticky stuff-violation flag, cleared only by `clear` or reset.
- ones_count  output  CW  current run of consecutive decoded ones, where CW = $clog2(STUFF_LEN+1).

## Operation
- Internal state:
  - prev_level: last sampled line level.
  - ones_cnt: CW bits, saturating.
  - All output registers.
- Per strobe (shift_enable=1, clear=0), compute dec = ~(d_plus_sync ^ prev_level), then set prev_level <= d_plus_sync.
- Normal bit, ones_cnt < STUFF_LEN:
  - d_orig <= dec; bit_valid <= 1.
  - ones_cnt <= dec ? ones_cnt+1 : 0.
- Stuff slot, ones_cnt == STUFF_LEN, dec == 0:
  - This is a stuffed bit and is dropped: bit_valid <= 0, d_orig unchanged.
  - ones_cnt <= 0.
- Stuff slot, ones_cnt == STUFF_LEN, dec == 1:
  - This is a violation: bit_valid <= 0, stuff_err <= 1, err_flag <= 1.
  - ones_cnt stays at STUFF_LEN, so every further 1 re-flags.
- No strobe (shift_enable=0):
  - prev_level, ones_cnt, d_orig and err_flag hold.
  - bit_valid <= 0 and stuff_err <= 0.
- clear=1, regardless of shift_enable:
  - prev_level <= IDLE_LEVEL, ones_cnt <= 0, d_orig <= 1.
  - bit_valid <= 0, stuff_err <= 0, err_flag <= 0.
  - The line sample in that cycle is discarded.
- ones_count = ones_cnt, driven combinationally from the register.

## Timing
- Reset values (async, n_rst low):
  - prev_level = IDLE_LEVEL, ones_cnt = 0.
  - d_orig = 1, bit_valid = 0, stuff_err = 0, err_flag = 0.
- Latency: d_orig, bit_valid and stuff_err update on the clock edge that samples shift_enable=1, so they are visible one cycle after the strobe.
- bit_valid and stuff_err are never high for more than one cycle per strobe, and never high together.
- Back-to-back strobes on consecutive cycles are legal; each strobe is processed independently.
- A strobe in the same cycle as clear is lost; the upstream logic guarantees clear only at packet boundaries.
- Reset released mid-packet: decoding restarts from IDLE_LEVEL; the first bit may decode wrongly, which is acceptable since the packet is already corrupt.
- The counter saturates at STUFF_LEN and never wraps.

## Test plan
- Reset and hold:
  - Assert n_rst low mid-operation -> d_orig=1, bit_valid=0, err_flag=0, ones_count=0 immediately.
  - Strobe-free cycles afterwards -> no output change.
- Plain decode (defaults, starting at level 1):
  - Line levels 0,0,1,0 on four strobes -> d_orig sequence 0,1,0,0.
  - bit_valid pulses once per strobe, one cycle late.
- Stuffed zero removal (STUFF_LEN=6):
  - Line held at 1 for 6 strobes -> six valid ones, ones_count=6.
  - 7th strobe with line 0 -> bit_valid stays 0 and ones_count=0.
  - 8th strobe with line 0 -> d_orig=1, valid.
- Stuff violation:
  - Line held at 1 for 7 strobes -> 7th produces stuff_err pulse, no bit_valid, err_flag=1.
  - 8th strobe at 1 -> stuff_err again.
- Clear priority:
  - Mid-run (ones_count=4, err_flag=1), assert clear with shift_enable=1 -> next cycle ones_count=0, err_flag=0, bit_valid=0.
  - Next strobe decodes relative to IDLE_LEVEL.
- Parameter variant (STUFF_LEN=3, IDLE_LEVEL=0):
  - Line held at 0 for 3 strobes -> ones_count=3.
  - 4th strobe with line 1 -> stuffed bit dropped.
  - Held at 0 on the 4th strobe instead -> stuff_err.

Source files
------------

// File: rtl/nrzi_unstuff_decoder.sv
// nrzi_unstuff_decoder
//   NRZI line decoder with bit-unstuffing and stuff-violation detection for
//   the USB receive path. The synchronised line is sampled on each bit
//   strobe. An unchanged level decodes as 1 and a transition decodes as 0.
//   After STUFF_LEN consecutive ones, the next bit is a stuff slot. A 0 in
//   that slot is a stuffed bit and is dropped. A 1 in that slot is a
//   violation.
//
// Parameters
//   STUFF_LEN   consecutive ones before an inserted zero (1..15)
//   IDLE_LEVEL  line level assumed at reset / after clear
//
// Ports
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   d_plus_sync  synchronised line level
//   shift_enable one-cycle bit strobe
//   clear        synchronous restart, overrides shift_enable
//   d_orig       last decoded data bit, held between strobes
//   bit_valid    one-cycle pulse, d_orig carries a new bit
//   stuff_err    one-cycle pulse, stuff violation seen
//   err_flag     sticky violation flag, cleared by clear or reset
//   ones_count   current run of consecutive decoded ones (saturating)
module nrzi_unstuff_decoder #(
   parameter  int unsigned STUFF_LEN  = 6,
   parameter  bit          IDLE_LEVEL = 1'b1,
   localparam int unsigned CW         = $clog2(STUFF_LEN + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          d_plus_sync,
   input  logic          shift_enable,
   input  logic          clear,
   output logic          d_orig,
   output logic          bit_valid,
   output logic          stuff_err,
   output logic          err_flag,
   output logic [CW-1:0] ones_count
);

   localparam logic [CW-1:0] STUFF_C = CW'(STUFF_LEN);

   logic          prev_q,  prev_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          dorig_q, dorig_d;
   logic          valid_q, valid_d;
   logic          serr_q,  serr_d;
   logic          eflag_q, eflag_d;
   logic          dec;

   assign dec = ~(d_plus_sync ^ prev_q);

   always_comb begin
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      dorig_d = dorig_q;
      valid_d = 1'b0;
      serr_d  = 1'b0;
      eflag_d = eflag_q;
      if (clear) begin
         prev_d  = IDLE_LEVEL;
         cnt_d   = '0;
         dorig_d = 1'b1;
         eflag_d = 1'b0;
      end else if (shift_enable) begin
         prev_d = d_plus_sync;
         if (cnt_q >= STUFF_C) begin
            // Stuff slot. A 0 here is the inserted bit and is dropped.
            // A 1 here is a violation. The counter stays saturated, so
            // every further 1 also flags a violation.
            if (dec) begin
               serr_d  = 1'b1;
               eflag_d = 1'b1;
            end else begin
               cnt_d = '0;
            end
         end else begin
            dorig_d = dec;
            valid_d = 1'b1;
            cnt_d   = dec ? cnt_q + CW'(1) : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_q  <= IDLE_LEVEL;
         cnt_q   <= '0;
         dorig_q <= 1'b1;
         valid_q <= 1'b0;
         serr_q  <= 1'b0;
         eflag_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         dorig_q <= dorig_d;
         valid_q <= valid_d;
         serr_q  <= serr_d;
         eflag_q <= eflag_d;
      end
   end

   assign d_orig     = dorig_q;
   assign bit_valid  = valid_q;
   assign stuff_err  = serr_q;
   assign err_flag   = eflag_q;
   assign ones_count = cnt_q;

endmodule

// File: tb/tb_nrzi_unstuff_decoder.sv
// Testbench for nrzi_unstuff_decoder.
//   The bench instantiates two decoders:
//     u_dut_a  STUFF_LEN=6, IDLE_LEVEL=1
//     u_dut_b  STUFF_LEN=3, IDLE_LEVEL=0
//   A behavioural model pushes the expected outputs for every driven cycle
//   into a queue. Each entry is popped and compared one cycle later.
module tb_nrzi_unstuff_decoder;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       line_a, se_a, clr_a, line_b, se_b, clr_b;
   logic       dorig_a, valid_a, serr_a, eflag_a;
   logic       dorig_b, valid_b, serr_b, eflag_b;
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   nrzi_unstuff_decoder #(.STUFF_LEN(6), .IDLE_LEVEL(1'b1)) u_dut_a (
      .clk(clk), .n_rst(n_rst), .d_plus_sync(line_a), .shift_enable(se_a),
      .clear(clr_a), .d_orig(dorig_a), .bit_valid(valid_a),
      .stuff_err(serr_a), .err_flag(eflag_a), .ones_count(cnt_a)
   );

   nrzi_unstuff_decoder #(.STUFF_LEN(3), .IDLE_LEVEL(1'b0)) u_dut_b (
      .clk(clk), .n_rst(n_rst), .d_plus_sync(line_b), .shift_enable(se_b),
      .clear(clr_b), .d_orig(dorig_b), .bit_valid(valid_b),
      .stuff_err(serr_b), .err_flag(eflag_b), .ones_count(cnt_b)
   );

   typedef struct {
      bit          d;
      bit          v;
      bit          s;
      bit          e;
      int unsigned n;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // behavioural model state
   bit          sel;      // 0: dut_a, 1: dut_b
   int unsigned m_len;
   bit          m_idle, m_prev, m_dorig, m_err;
   int unsigned m_run;

   // last observed outputs of the selected DUT
   bit          o_d, o_v, o_s, o_e;
   int unsigned o_n;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic sample();
      if (sel == 1'b0) begin
         o_d = dorig_a; o_v = valid_a; o_s = serr_a; o_e = eflag_a; o_n = cnt_a;
      end else begin
         o_d = dorig_b; o_v = valid_b; o_s = serr_b; o_e = eflag_b; o_n = cnt_b;
      end
   endtask

   task automatic model_reset();
      m_prev  = m_idle;
      m_run   = 0;
      m_dorig = 1'b1;
      m_err   = 1'b0;
   endtask

   // Asynchronous reset issued between clock edges. The outputs are checked
   // right after n_rst falls, before any clock edge occurs.
   task automatic do_reset();
      @(negedge clk);
      line_a = 1'b0; se_a = 1'b0; clr_a = 1'b0;
      line_b = 1'b0; se_b = 1'b0; clr_b = 1'b0;
      #1 n_rst = 1'b0;
      #1 sample();
      check_eq("rst_d_orig", o_d, 1);
      check_eq("rst_valid",  o_v, 0);
      check_eq("rst_serr",   o_s, 0);
      check_eq("rst_eflag",  o_e, 0);
      check_eq("rst_count",  o_n, 0);
      #1 n_rst = 1'b1;
      model_reset();
   endtask

   task automatic step(input bit line, input bit se, input bit clr);
      exp_t e;
      exp_t got;
      bit   dec;
      @(negedge clk);
      if (sel == 1'b0) begin
         line_a = line; se_a = se; clr_a = clr;
      end else begin
         line_b = line; se_b = se; clr_b = clr;
      end
      e.v = 1'b0;
      e.s = 1'b0;
      if (clr) begin
         model_reset();
      end else if (se) begin
         dec    = (line == m_prev);
         m_prev = line;
         if (m_run == m_len) begin
            if (dec) begin
               e.s   = 1'b1;
               m_err = 1'b1;
            end else begin
               m_run = 0;
            end
         end else begin
            m_dorig = dec;
            e.v     = 1'b1;
            m_run   = dec ? m_run + 1 : 0;
         end
      end
      e.d = m_dorig;
      e.e = m_err;
      e.n = m_run;
      sb.push_back(e);
      @(posedge clk);
      #1 sample();
      if (sb.size() == 0) begin
         check_eq("sb_empty", 1, 0);
      end else begin
         got = sb.pop_front();
         check_eq("d_orig",     o_d, got.d);
         check_eq("bit_valid",  o_v, got.v);
         check_eq("stuff_err",  o_s, got.s);
         check_eq("err_flag",   o_e, got.e);
         check_eq("ones_count", o_n, got.n);
         check_eq("valid_serr_excl", o_v & o_s, 0);
      end
   endtask

   task automatic random_run(input int unsigned cycles);
      bit l;
      for (int unsigned i = 0; i < cycles; i++) begin
         // Repeat the previous level most of the time so that long runs of
         // ones reach the stuff slot.
         l = ($urandom_range(0, 4) != 0) ? m_prev : ~m_prev;
         step(l, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end
   endtask

   initial begin
      bit plain_line [4];
      bit plain_exp  [4];
      n_rst  = 1'b0;
      line_a = 1'b0; se_a = 1'b0; clr_a = 1'b0;
      line_b = 1'b0; se_b = 1'b0; clr_b = 1'b0;
      plain_line = '{1'b0, 1'b0, 1'b1, 1'b0};
      plain_exp  = '{1'b0, 1'b1, 1'b0, 1'b0};

      // ---------------- dut_a: STUFF_LEN=6, IDLE_LEVEL=1 ----------------
      sel = 1'b0; m_len = 6; m_idle = 1'b1;
      do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // plain decode
      for (int i = 0; i < 4; i++) begin
         step(plain_line[i], 1'b1, 1'b0);
         check_eq("plain_d", o_d, plain_exp[i]);
         check_eq("plain_v", o_v, 1);
      end
      step(1'b0, 1'b0, 1'b0);
      check_eq("plain_gap_v", o_v, 0);

      // stuffed zero removal
      step(1'b0, 1'b0, 1'b1);
      repeat (6) step(1'b1, 1'b1, 1'b0);
      check_eq("six_ones_cnt", o_n, 6);
      step(1'b0, 1'b1, 1'b0);
      check_eq("stuffed_v", o_v, 0);
      check_eq("stuffed_cnt", o_n, 0);
      step(1'b0, 1'b1, 1'b0);
      check_eq("after_stuff_d", o_d, 1);
      check_eq("after_stuff_v", o_v, 1);

      // stuff violation
      step(1'b0, 1'b0, 1'b1);
      repeat (6) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check_eq("viol_serr", o_s, 1);
      check_eq("viol_v", o_v, 0);
      check_eq("viol_eflag", o_e, 1);
      step(1'b1, 1'b1, 1'b0);
      check_eq("viol2_serr", o_s, 1);
      step(1'b1, 1'b0, 1'b0);
      check_eq("viol_gap_serr", o_s, 0);
      check_eq("eflag_sticky", o_e, 1);

      // clear priority mid-run
      step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b1, 1'b0);
      check_eq("pre_clr_cnt", o_n, 4);
      check_eq("pre_clr_eflag", o_e, 1);
      step(1'b0, 1'b1, 1'b1);
      check_eq("clr_cnt", o_n, 0);
      check_eq("clr_eflag", o_e, 0);
      check_eq("clr_v", o_v, 0);
      step(1'b0, 1'b1, 1'b0);
      check_eq("post_clr_d", o_d, 0);

      random_run(300);

      // async reset mid-operation
      repeat (3) step(1'b1, 1'b1, 1'b0);
      do_reset();
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // ---------------- dut_b: STUFF_LEN=3, IDLE_LEVEL=0 ----------------
      sel = 1'b1; m_len = 3; m_idle = 1'b0;
      do_reset();
      repeat (3) step(1'b0, 1'b1, 1'b0);
      check_eq("b_cnt3", o_n, 3);
      step(1'b1, 1'b1, 1'b0);
      check_eq("b_stuffed_v", o_v, 0);
      check_eq("b_stuffed_serr", o_s, 0);
      step(1'b0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_eq("b_viol_serr", o_s, 1);
      check_eq("b_viol_eflag", o_e, 1);

      random_run(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
